// File: rtl/wisc_pkg.sv
// Shared definitions for the WiscSP13 write-back stage.
// Contents:
//   DW, NREG, RA_W : data width, register count, register address width
//   wb_sel_e       : write-back data source
//   halt_state_e   : retire-side halt state
//   wb_sel_f       : maps the MEM/WB control bits to a write-back source
package wisc_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int RA_W = 3;

  typedef enum logic [1:0] {
    WB_SEL_EX   = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_LINK = 2'd2
  } wb_sel_e;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } halt_state_e;

  // The link select outranks the load select, so a JAL/JALR always
  // writes PC+2 even if mem_to_reg is set as well.
  function automatic wb_sel_e wb_sel_f(input logic jal_jalr, input logic mem_to_reg);
    wb_sel_e sel;
    if (jal_jalr) begin
      sel = WB_SEL_LINK;
    end else if (mem_to_reg) begin
      sel = WB_SEL_MEM;
    end else begin
      sel = WB_SEL_EX;
    end
    return sel;
  endfunction

endpackage

// File: rtl/wb_regfile_rf_core.sv
// Register array: NREG x DW storage with one synchronous write port and
// two combinational read ports. No bypass; the array is cleared by reset.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   we, wr_addr,
//   wr_data         : write port, lands on the rising edge
//   rd_addr_a/_b    : read addresses
//   rd_data_a/_b    : combinational read data
module rf_core #(
  parameter int DW   = wisc_pkg::DW,
  parameter int NREG = wisc_pkg::NREG,
  parameter int RA_W = wisc_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RA_W-1:0] wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [RA_W-1:0] rd_addr_a,
  output logic [DW-1:0]   rd_data_a,
  input  logic [RA_W-1:0] rd_addr_b,
  output logic [DW-1:0]   rd_data_b
);

  logic [DW-1:0] mem_r [NREG];

  // Array storage: cleared by reset, written on the rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (we) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r[wr_addr] <= mem_r[wr_addr];
    end
  end

  assign rd_data_a = mem_r[rd_addr_a];
  assign rd_data_b = mem_r[rd_addr_b];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus architectural register file.
// Selects the write-back value (link / load / execute), commits it into
// rf_core, provides write-before-read bypassed decode reads, tracks the
// sticky halt and counts committed writes (saturating).
// Ports:
//   clk, rst                    : clock, asynchronous active-low reset
//   WB_*  inputs                : MEM/WB pipeline register outputs
//   ID_rs_addr / ID_rt_addr     : decode read addresses
//   ID_rs_data / ID_rt_data     : bypassed read data (combinational)
//   WB_wr_data                  : selected write-back value
//   halted                      : sticky halt flag (registered)
//   commit_cnt                  : committed write count (registered)
module wb_regfile
  import wisc_pkg::wb_sel_e, wisc_pkg::halt_state_e, wisc_pkg::wb_sel_f,
         wisc_pkg::WB_SEL_EX, wisc_pkg::WB_SEL_MEM, wisc_pkg::WB_SEL_LINK,
         wisc_pkg::RUN, wisc_pkg::HALTED;
#(
  parameter int DW   = wisc_pkg::DW,
  parameter int NREG = wisc_pkg::NREG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW-1:0]           WB_PC2,
  input  logic [DW-1:0]           WB_EX_out,
  input  logic [DW-1:0]           WB_mem_data,
  input  logic [$clog2(NREG)-1:0] WB_rd_addr,
  input  logic                    WB_reg_write,
  input  logic                    WB_mem_to_reg,
  input  logic                    WB_JAL_JALR,
  input  logic                    WB_halt,
  input  logic [$clog2(NREG)-1:0] ID_rs_addr,
  input  logic [$clog2(NREG)-1:0] ID_rt_addr,
  output logic [DW-1:0]           ID_rs_data,
  output logic [DW-1:0]           ID_rt_data,
  output logic [DW-1:0]           WB_wr_data,
  output logic                    halted,
  output logic [15:0]             commit_cnt
);

  localparam int RA_W = $clog2(NREG);

  wb_sel_e       wb_sel_s;
  logic [DW-1:0] wr_data_s;
  logic          we_s;
  logic [DW-1:0] arr_rs_s;
  logic [DW-1:0] arr_rt_s;
  halt_state_e   state_r;
  logic [15:0]   commit_cnt_r;

  assign wb_sel_s = wb_sel_f(WB_JAL_JALR, WB_mem_to_reg);

  // Write-back data mux.
  always_comb begin
    wr_data_s = WB_EX_out;
    case (wb_sel_s)
      WB_SEL_LINK: wr_data_s = WB_PC2;
      WB_SEL_MEM:  wr_data_s = WB_mem_data;
      WB_SEL_EX:   wr_data_s = WB_EX_out;
      default:     wr_data_s = WB_EX_out;
    endcase
  end

  // The retiring HALT itself never commits, nor does anything after it.
  assign we_s = WB_reg_write & ~WB_halt & (state_r == RUN);

  rf_core #(
    .DW   (DW),
    .NREG (NREG),
    .RA_W (RA_W)
  ) u_rf_core (
    .clk       (clk),
    .rst       (rst),
    .we        (we_s),
    .wr_addr   (WB_rd_addr),
    .wr_data   (wr_data_s),
    .rd_addr_a (ID_rs_addr),
    .rd_data_a (arr_rs_s),
    .rd_addr_b (ID_rt_addr),
    .rd_data_b (arr_rt_s)
  );

  // Write-before-read bypass on both decode ports.
  always_comb begin
    ID_rs_data = arr_rs_s;
    ID_rt_data = arr_rt_s;
    if (we_s && (ID_rs_addr == WB_rd_addr)) begin
      ID_rs_data = wr_data_s;
    end else begin
      ID_rs_data = arr_rs_s;
    end
    if (we_s && (ID_rt_addr == WB_rd_addr)) begin
      ID_rt_data = wr_data_s;
    end else begin
      ID_rt_data = arr_rt_s;
    end
  end

  // Halt state machine; HALTED is only left through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
    end else begin
      case (state_r)
        RUN:     state_r <= WB_halt ? HALTED : RUN;
        HALTED:  state_r <= HALTED;
        default: state_r <= HALTED;
      endcase
    end
  end

  // Saturating count of committed writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_cnt_r <= 16'h0000;
    end else if (we_s && (commit_cnt_r != 16'hFFFF)) begin
      commit_cnt_r <= commit_cnt_r + 16'h0001;
    end else begin
      commit_cnt_r <= commit_cnt_r;
    end
  end

  assign WB_wr_data = wr_data_s;
  assign halted     = (state_r == HALTED);
  assign commit_cnt = commit_cnt_r;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the WiscSP13 pipeline. Consumes the MEM/WB pipeline register outputs and selects the write-back value: memory data, execute result or link address. Commits that value into an 8×16 register file with one write port and two read ports. Supplies decode with bypassed read data, and latches the halt that retires out of the pipeline.

## Interface
Parameters:
- `DW`, 16: register/data width.
- `NREG`, 8: register count; the address width is log2(`NREG`) = 3.

Ports:
- `clk`  in  1  sole clock; every state element updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; must be held low at least one `clk` edge.
- `WB_PC2`  in  16  PC+2 of the retiring instruction (link value).
- `WB_EX_out`  in  16  execute-stage result.
- `WB_mem_data`  in  16  load data.
- `WB_rd_addr`  in  3  destination register.
- `WB_reg_write`  in  1  commit request.
- `WB_mem_to_reg`  in  1  select load data.
- `WB_JAL_JALR`  in  1  select link value (`WB_PC2`).
- `WB_halt`  in  1  HALT instruction is retiring.
- `ID_rs_addr`  in  3  decode read port 1 address.
- `ID_rt_addr`  in  3  decode read port 2 address.
- `ID_rs_data`  out  16  read port 1 data, bypassed.
- `ID_rt_data`  out  16  read port 2 data, bypassed.
- `WB_wr_data`  out  16  selected write-back value, forwarded to EX.
- `halted`  out  1  sticky halt flag.
- `commit_cnt`  out  16  count of committed register writes.

## Operation
- Write-data select, priority order:
  - `WB_JAL_JALR` = 1 → `WB_PC2`.
  - otherwise `WB_mem_to_reg` = 1 → `WB_mem_data`.
  - otherwise → `WB_EX_out`.
- `WB_wr_data` always shows the selected value, whatever `WB_reg_write` is.
- Commit enable `we` = `WB_reg_write` & ~`WB_halt` & ~`halted`.
- Every one of R0..R7 is a general register; R0 is not hardwired to zero.
- Read ports:
  - Each port is a combinational read of the array.
  - If `we` = 1 and the port address equals `WB_rd_addr`, the port returns `WB_wr_data` instead (write-before-read bypass).
  - Both ports may bypass in the same cycle.
- Halt state machine:
  - RUN → HALTED on a rising edge with `WB_halt` = 1.
  - HALTED is left only by reset.
  - In HALTED, all commits are suppressed and reads keep working.
- `commit_cnt`:
  - Increments by 1 on every edge where `we` = 1.
  - Saturates at 0xFFFF; no wrap.

## Timing
- Reset values: all registers 0x0000, `halted` = 0, `commit_cnt` = 0.
- Read-port outputs are combinational and reflect reset contents (0x0000) immediately.
- Reset is asynchronous: asserting `rst` mid-operation clears state at once, with no clock needed.
- Commit latency: the write lands on the edge that ends the WB cycle.
  - A read in that same cycle gets the new value through the bypass.
  - Reads in later cycles get it from the array.
- Same-address back-to-back writes: the later write wins. The bypass reflects only the current cycle's write.
- A cycle with `WB_halt` = 1 never commits, even if `WB_reg_write` = 1.
- `halted` rises on the edge after `WB_halt` was sampled high.

## Structure
- Shared package `wisc_pkg`:
  - `DW`, `NREG`, `RA_W` = 3.
  - enum `wb_sel_e` {`WB_SEL_EX`, `WB_SEL_MEM`, `WB_SEL_LINK`}.
  - `halt_state_e` {`RUN`, `HALTED`}.
- Sub-module `rf_core`:
  - Contains the 8×`DW` array with 1 write and 2 read ports, no bypass.
  - `wb_regfile` adds write-data select, bypass, halt logic and counter around it.

## Test plan
- Reset, then read all 8 addresses → every read returns 0x0000; `halted` = 0; `commit_cnt` = 0.
- `WB_reg_write` = 1, `WB_rd_addr` = 3, `WB_EX_out` = 0x1234, `ID_rs_addr` = 3 in the same cycle → `ID_rs_data` = 0x1234 before the edge; after the edge the array read also gives 0x1234; `commit_cnt` = 1.
- `WB_JAL_JALR` = 1, `WB_mem_to_reg` = 1, `WB_PC2` = 0x0042, `WB_mem_data` = 0xBEEF, `rd` = 7 → R7 = 0x0042 (link select has priority).
- Write R5 = 0xAAAA, then `WB_halt` = 1 with `reg_write` = 1 and `rd` = 5, `EX_out` = 0x5555, then further writes to R5 →
  - R5 stays 0xAAAA;
  - `halted` = 1 from the edge after the halt;
  - `commit_cnt` stops counting.
- Preload `commit_cnt` to 0xFFFE with back-to-back writes, then do 3 more writes → `commit_cnt` holds at 0xFFFF.
- Write R2 = 0x0F0F, drop `rst` low between clock edges → R2 reads 0x0000 and `halted` = 0 with no clock edge needed.
